// File: rtl/mux_pkg.sv
// mux_pkg: shared state and mode encodings for the channel scan mux.
package mux_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, MANUAL} scan_state_t;
  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;
endpackage

// File: rtl/mux_nx1.sv
// mux_nx1: parametrised combinational N:1 mux; out-of-range selects yield zero.
module mux_nx1 #(
  parameter int N  = 16,
  parameter int W  = 1,
  parameter int SW = $clog2(N)
) (
  input  logic [N*W-1:0] din,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) if (sel == SW'(i)) dout = din[i*W +: W];
  end
endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: auto-scan / manual channel selector with registered outputs.
module chan_scan_mux
  import mux_pkg::*;
#(
  parameter int N_CH  = 16,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SW   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel_in,
  input  logic [N_CH*W-1:0] din,
  output logic [W-1:0]    dout,
  output logic [SW-1:0]   ch_out,
  output logic            valid,
  output logic            wrap
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  scan_state_t state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d, ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] dout_q, dout_d, mux_y;
  logic valid_q, valid_d, wrap_q, wrap_d;
  logic scanning, adv, last, sel_ok, active;
  mux_nx1 #(.N(N_CH), .W(W), .SW(SW)) u_mux (.din(din), .sel(ptr_q), .dout(mux_y));
  // Outputs lag ptr by one cycle and only track it while the FSM is active.
  always_comb begin
    state_d  = !en ? IDLE : (mode == MODE_MANUAL ? MANUAL : SCAN);
    scanning = state_q == SCAN && state_d == SCAN;
    adv      = scanning && cnt_q == CW'(DWELL - 1);
    last     = ptr_q == SW'(N_CH - 1);
    sel_ok   = {1'b0, sel_in} < (SW + 1)'(N_CH);
    active   = state_q != IDLE;
    cnt_d    = ((state_d == SCAN && state_q != SCAN) || adv) ? '0 : (scanning ? cnt_q + CW'(1) : cnt_q);
    ptr_d    = adv ? (last ? '0 : ptr_q + SW'(1))
             : (state_q == MANUAL && state_d == MANUAL && sel_ok) ? sel_in : ptr_q;
    dout_d   = active ? mux_y : dout_q;
    ch_d     = active ? ptr_q : ch_q;
    valid_d  = active;
    wrap_d   = adv && last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end
  assign dout   = dout_q;
  assign ch_out = ch_q;
  assign valid  = valid_q;
  assign wrap   = wrap_q;
endmodule
